// File: rtl/brick_game_core.sv
// Brick-breaker game engine: 16x12 playfield, paddle, bouncing ball, 64-brick wall.
// All game state advances only on tick; the bitmap is registered alongside the state.
module brick_game_core #(
    parameter logic [3:0] KEY_LEFT  = 4'd4,
    parameter logic [3:0] KEY_RIGHT = 4'd6,
    parameter logic [3:0] KEY_START = 4'd5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick,
    input  logic [3:0]   control,
    output logic [191:0] data,
    output logic [9:0]   score,
    output logic [1:0]   lives,
    output logic         game_over,
    output logic         win
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAME_OVER, S_WIN} state_t;

    localparam logic [63:0] RST_BRICKS = {64{1'b1}};
    localparam logic [3:0]  RST_PX     = 4'd6;
    localparam logic [3:0]  RST_BX     = 4'd7;
    localparam logic [3:0]  RST_BY     = 4'd10;
    localparam logic [9:0]  SCORE_MAX  = 10'd999;

    state_t       r_state,  w_state_n;
    logic [63:0]  r_bricks, w_bricks_n;
    logic [3:0]   r_px,     w_px_n;
    logic [3:0]   r_bx,     w_bx_n;
    logic [3:0]   r_by,     w_by_n;
    logic         r_dx_neg, w_dx_neg_n;
    logic         r_dy_neg, w_dy_neg_n;
    logic [9:0]   r_score,  w_score_n;
    logic [1:0]   r_lives,  w_lives_n;
    logic [191:0] r_data;

    function automatic logic [191:0] compose(input logic [63:0] b, input logic [3:0] p,
                                             input logic [3:0] x, input logic [3:0] y);
        logic [191:0] f;
        f = {128'd0, b};
        f = f | (192'd1 << {y, x});
        f = f | (192'd7 << (8'd176 + {4'd0, p}));
        return f;
    endfunction

    // Paddle candidate after this tick's key; collisions still use the old r_px.
    logic [3:0] w_px_move;
    assign w_px_move = (control == KEY_LEFT  && r_px != 4'd0)  ? r_px - 4'd1 :
                       (control == KEY_RIGHT && r_px < 4'd13) ? r_px + 4'd1 : r_px;

    logic [4:0]  w_sx, w_sy;
    logic        w_side, w_top, w_brick_hit, w_pad_cover;
    logic [3:0]  w_nx, w_ny;
    logic [5:0]  w_brick_idx;
    logic [63:0] w_bricks_clr;

    assign w_sx         = {1'b0, r_bx} + (r_dx_neg ? 5'h1F : 5'h01);
    assign w_sy         = {1'b0, r_by} + (r_dy_neg ? 5'h1F : 5'h01);
    assign w_side       = w_sx[4];
    assign w_top        = w_sy[4];
    assign w_nx         = w_side ? (r_dx_neg ? r_bx + 4'd1 : r_bx - 4'd1) : w_sx[3:0];
    assign w_ny         = w_sy[3:0];
    assign w_brick_idx  = {w_ny[1:0], w_nx};
    assign w_brick_hit  = !w_top && (w_ny[3:2] == 2'b00) && r_bricks[w_brick_idx];
    assign w_pad_cover  = ({1'b0, w_nx} >= {1'b0, r_px}) && ({1'b0, w_nx} <= {1'b0, r_px} + 5'd2);
    assign w_bricks_clr = r_bricks & ~(64'd1 << w_brick_idx);

    always_comb begin
        // NOTE: every next-state signal defaults to its register so no path infers a latch.
        w_state_n  = r_state;
        w_bricks_n = r_bricks;
        w_px_n     = r_px;
        w_bx_n     = r_bx;
        w_by_n     = r_by;
        w_dx_neg_n = r_dx_neg;
        w_dy_neg_n = r_dy_neg;
        w_score_n  = r_score;
        w_lives_n  = r_lives;
        case (r_state)
            S_IDLE: begin
                w_px_n     = w_px_move;
                w_bx_n     = w_px_move + 4'd1;
                w_by_n     = RST_BY;
                w_dx_neg_n = 1'b0;
                w_dy_neg_n = 1'b1;
                if (control == KEY_START) w_state_n = S_PLAY;
            end
            S_PLAY: begin
                w_px_n     = w_px_move;
                w_dx_neg_n = r_dx_neg ^ w_side;
                if (w_top) begin
                    w_dy_neg_n = 1'b0;
                    w_bx_n     = w_nx;
                    w_by_n     = r_by + 4'd1;
                end else if (w_brick_hit) begin
                    w_bricks_n = w_bricks_clr;
                    w_score_n  = (r_score == SCORE_MAX) ? r_score : r_score + 10'd1;
                    w_dy_neg_n = ~r_dy_neg;
                    if (w_bricks_clr == 64'd0) w_state_n = S_WIN;
                end else if (w_ny == 4'd11) begin
                    if (w_pad_cover) begin
                        w_dy_neg_n = 1'b1;
                    end else begin
                        w_lives_n = r_lives - 2'd1;
                        if (r_lives == 2'd1) begin
                            w_state_n = S_GAME_OVER;
                        end else begin
                            w_state_n  = S_IDLE;
                            w_bx_n     = w_px_move + 4'd1;
                            w_by_n     = RST_BY;
                            w_dx_neg_n = 1'b0;
                            w_dy_neg_n = 1'b1;
                        end
                    end
                end else begin
                    w_bx_n = w_nx;
                    w_by_n = w_ny;
                end
            end
            default: begin
                if (control == KEY_START) begin
                    w_state_n  = S_IDLE;
                    w_bricks_n = RST_BRICKS;
                    w_px_n     = RST_PX;
                    w_bx_n     = RST_BX;
                    w_by_n     = RST_BY;
                    w_dx_neg_n = 1'b0;
                    w_dy_neg_n = 1'b1;
                    w_score_n  = 10'd0;
                    w_lives_n  = 2'd3;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_bricks <= RST_BRICKS;
            r_px     <= RST_PX;
            r_bx     <= RST_BX;
            r_by     <= RST_BY;
            r_dx_neg <= 1'b0;
            r_dy_neg <= 1'b1;
            r_score  <= 10'd0;
            r_lives  <= 2'd3;
            r_data   <= compose(RST_BRICKS, RST_PX, RST_BX, RST_BY);
        end else if (tick) begin
            r_state  <= w_state_n;
            r_bricks <= w_bricks_n;
            r_px     <= w_px_n;
            r_bx     <= w_bx_n;
            r_by     <= w_by_n;
            r_dx_neg <= w_dx_neg_n;
            r_dy_neg <= w_dy_neg_n;
            r_score  <= w_score_n;
            r_lives  <= w_lives_n;
            r_data   <= compose(w_bricks_n, w_px_n, w_bx_n, w_by_n);
        end
    end

    assign data      = r_data;
    assign score     = r_score;
    assign lives     = r_lives;
    assign game_over = (r_state == S_GAME_OVER);
    assign win       = (r_state == S_WIN);

endmodule

// File: doc/brick_game_core.md
BRICK_GAME_CORE -- requirements
Module: brick_game_core

Interface
REQ-001 Parameters (name, default, meaning): KEY_LEFT, 4'd4, control code for paddle left; KEY_RIGHT, 4'd6, control code for paddle right; KEY_START, 4'd5, control code for serve/restart.
REQ-002 clock  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  asynchronous, active-high; forces every register to its reset value immediately.
REQ-004 tick  input  1  game-step enable, one-clock pulse; no state SHALL change on cycles without tick.
REQ-005 control  input  4  current keypad code; any value other than the three parameter codes means "no action".
REQ-006 data  output  192  playfield bitmap, 16 columns x 12 rows, bit index = row*16+col, row 0 at top; 1 = lit.
REQ-007 score  output  10  bricks destroyed, binary, range 0..999.
REQ-008 lives  output  2  remaining balls, 0..3.
REQ-009 game_over  output  1  high while in GAME_OVER.
REQ-010 win  output  1  high while in WIN.

Function
REQ-011 Internal state: brick map (rows 0-3, 64 bits), paddle left column px (0..13, paddle covers px..px+2 in row 11), ball (bx 0..15, by 0..11), direction dx,dy each +/-1, FSM state IDLE/PLAY/GAME_OVER/WIN.
REQ-012 data SHALL be registered: OR of brick map, ball pixel and paddle pixels, reflecting state committed on the previous tick (one-cycle latency after tick).
REQ-013 Paddle, IDLE and PLAY only: on tick, control==KEY_LEFT and px>0 -> px-1; control==KEY_RIGHT and px<13 -> px+1; else unchanged.
REQ-014 IDLE: ball SHALL sit at (px_new+1, 10) with dx=+1, dy=-1; tick with control==KEY_START -> PLAY.
REQ-015 PLAY, per tick, ball collision SHALL use the paddle position from before this tick's paddle update.
REQ-016 X step: nx=bx+dx; if nx<0 or nx>15, dx negates and nx=bx-dx(old).
REQ-017 Y step: ny=by+dy; if ny<0, dy negates and ball moves to (nx, by+1) with no brick check that tick.
REQ-018 Brick hit: if brick at (nx,ny) set, that brick clears, score increments, dy negates, ball position stays (bx,by).
REQ-019 Paddle hit: if ny==11 and old px<=nx<=old px+2, dy becomes -1, ball position stays (bx,by).
REQ-020 Miss: ny==11 and not covered -> lives decrements; lives becoming 0 -> GAME_OVER, else -> IDLE (bricks and score kept).
REQ-021 Otherwise the ball SHALL move to (nx,ny).
REQ-022 Simultaneous side-wall and top-wall reflection SHALL negate both dx and dy in the same tick.
REQ-023 Score SHALL saturate at 999; no wrap.
REQ-024 Last brick cleared -> WIN on the same tick-update; ball and paddle freeze.
REQ-025 GAME_OVER/WIN: paddle and ball frozen; tick with KEY_START -> full restart to reset-equivalent state in IDLE.
REQ-026 Control codes other than those listed for the current state SHALL be ignored.

Reset
REQ-027 On reset: state IDLE, brick rows 0-3 all set, px=6, ball (7,10), dx=+1, dy=-1, score 0, lives 3, game_over 0, win 0, data equal to that composite (rows 0-3 = 16'hFFFF, bit 167 set, bits 182-184 set).
REQ-028 Reset asserted mid-PLAY SHALL discard all progress within the same cycle, without waiting for clock or tick.

Verification
REQ-029 Reset release, no tick for 100 clocks -> data, score=0, lives=3 unchanged from REQ-027.
REQ-030 IDLE, tick with KEY_LEFT x8 -> px=0 after 6, held at 0; ball tracks at (1,10).
REQ-031 Serve from reset, ticks only -> first brick hit clears a row-3 brick, score=1, dy flips to +1.
REQ-032 Ball at (15,5), dx=+1, dy=-1 -> next tick ball at (14,4), dx=-1; ball at (0,0), dx=-1, dy=-1 -> (1,1), both flipped.
REQ-033 Paddle moved away, ball reaches row 10 descending -> lives 3->2, state IDLE; third miss -> game_over=1, KEY_START tick -> full reset state.
REQ-034 Preload score 999 (force) and hit brick -> score stays 999; clearing final brick -> win=1, further ticks without KEY_START change nothing.
